// File: rtl/fir_fp_pkg.sv
// Shared single-precision constants and the converter FSM encoding used by
// the FIR datapath blocks.
package fir_fp_pkg;

  localparam int unsigned FP_EXP_BIAS = 127;
  localparam int unsigned FP_MANT_W   = 23;

  localparam logic [31:0] SAT_POS = 32'h7FFF_FFFF;
  localparam logic [31:0] SAT_NEG = 32'h8000_0000;

  typedef enum logic [2:0] {
    StIdle,
    StPrep,
    StShift,
    StRound,
    StDone
  } cvt_state_e;

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on an unsigned magnitude with guard/sticky, then apply
// the sign and clip a positive 2^31 to the largest positive value.
module fp_round_rne
  import fir_fp_pkg::*;
(
  input  logic [31:0] mag_i,
  input  logic        guard_i,
  input  logic        sticky_i,
  input  logic        sign_i,
  output logic [31:0] data_o,
  output logic        ovf_o
);

  logic        inc;
  logic [31:0] rounded;

  always_comb begin
    inc     = guard_i & (sticky_i | mag_i[0]);
    rounded = mag_i + {31'd0, inc};
    data_o  = rounded;
    ovf_o   = 1'b0;
    // -2^31 is representable, +2^31 is not.
    if (!sign_i && (rounded == SAT_NEG)) begin
      data_o = SAT_POS;
      ovf_o  = 1'b1;
    end else if (sign_i) begin
      data_o = 32'd0 - rounded;
    end
  end

endmodule

// File: rtl/fp32_to_fixed.sv
// Converts an IEEE-754 single into signed 32-bit fixed point with FRAC fraction
// bits, using a one-bit-per-cycle shifter and round-to-nearest-even.
module fp32_to_fixed
  import fir_fp_pkg::*;
#(
  parameter int unsigned FRAC = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_ovf,
  output logic        out_inv
);

  // Value = M * 2^k with k = E - bias - mantissa width + FRAC.
  localparam logic signed [9:0] KOff = 10'(FRAC) - 10'(FP_EXP_BIAS + FP_MANT_W);

  cvt_state_e  state_q;
  logic [31:0] word_q;
  logic [31:0] mag_q;
  logic        guard_q;
  logic        sticky_q;
  logic        sign_q;
  logic        shl_q;
  logic [4:0]  cnt_q;

  logic                 sign_w;
  logic [7:0]           exp_w;
  logic [FP_MANT_W-1:0] frac_w;
  logic signed [9:0]    k_w;
  logic [4:0]           n_w;
  logic [31:0]          sat_w;
  logic [31:0]          rnd_data;
  logic                 rnd_ovf;

  assign sign_w = word_q[31];
  assign exp_w  = word_q[30:23];
  assign frac_w = word_q[22:0];
  assign k_w    = $signed({2'b00, exp_w}) + KOff;
  // Only used when -24 <= k <= 7, so the low five bits carry |k|.
  assign n_w    = k_w[9] ? (5'd0 - k_w[4:0]) : k_w[4:0];
  assign sat_w  = sign_w ? SAT_NEG : SAT_POS;

  assign in_ready = (state_q == StIdle);

  fp_round_rne u_round (
    .mag_i   (mag_q),
    .guard_i (guard_q),
    .sticky_i(sticky_q),
    .sign_i  (sign_q),
    .data_o  (rnd_data),
    .ovf_o   (rnd_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      word_q    <= 32'd0;
      mag_q     <= 32'd0;
      guard_q   <= 1'b0;
      sticky_q  <= 1'b0;
      sign_q    <= 1'b0;
      shl_q     <= 1'b0;
      cnt_q     <= 5'd0;
      out_valid <= 1'b0;
      out_data  <= 32'd0;
      out_ovf   <= 1'b0;
      out_inv   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            word_q  <= in_data;
            out_ovf <= 1'b0;
            out_inv <= 1'b0;
            state_q <= StPrep;
          end
        end
        StPrep: begin
          sign_q   <= sign_w;
          mag_q    <= {8'd0, 1'b1, frac_w};
          guard_q  <= 1'b0;
          sticky_q <= 1'b0;
          shl_q    <= ~k_w[9];
          cnt_q    <= n_w;
          if (exp_w == 8'd0 || k_w <= -10'sd25) begin
            out_data  <= 32'd0;
            out_valid <= 1'b1;
            state_q   <= StDone;
          end else if (exp_w == 8'hFF && frac_w != '0) begin
            out_data  <= 32'd0;
            out_inv   <= 1'b1;
            out_valid <= 1'b1;
            state_q   <= StDone;
          end else if (exp_w == 8'hFF || k_w >= 10'sd8) begin
            out_data  <= sat_w;
            out_ovf   <= 1'b1;
            out_valid <= 1'b1;
            state_q   <= StDone;
          end else if (n_w != 5'd0) begin
            state_q <= StShift;
          end else begin
            state_q <= StRound;
          end
        end
        StShift: begin
          if (shl_q) begin
            mag_q <= mag_q << 1;
          end else begin
            mag_q    <= mag_q >> 1;
            guard_q  <= mag_q[0];
            sticky_q <= sticky_q | guard_q;
          end
          cnt_q <= cnt_q - 5'd1;
          if (cnt_q == 5'd1) begin
            state_q <= StRound;
          end
        end
        StRound: begin
          out_data  <= rnd_data;
          out_ovf   <= rnd_ovf;
          out_valid <= 1'b1;
          state_q   <= StDone;
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_to_fixed.sv
// Directed vector bench for fp32_to_fixed (FRAC=15): table of conversions plus
// backpressure and reset-in-flight sequences.
module tb_fp32_to_fixed;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_ovf;
  logic        out_inv;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] din;
    logic [31:0] dout;
    logic        ovf;
    logic        inv;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  fp32_to_fixed #(.FRAC(15)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_ovf  (out_ovf),
    .out_inv  (out_inv)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one word, return edges from accept until out_valid (100 = timeout).
  task automatic send(input logic [31:0] d, output int lat);
    @(negedge clk);
    check("in_ready before accept", {31'd0, in_ready}, 32'd1);
    in_data  = d;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("flags cleared at accept", {30'd0, out_ovf, out_inv}, 32'd0);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic drain();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("out_valid drop after drain", {31'd0, out_valid}, 32'd0);
  endtask

  function automatic void add(input logic [31:0] din, input logic [31:0] dout,
                              input logic ovf, input logic inv, input int lat);
    vec_t v;
    v.din = din; v.dout = dout; v.ovf = ovf; v.inv = inv; v.lat = lat;
    vecs.push_back(v);
  endfunction

  initial begin
    int   lat;
    int   seen;
    logic [31:0] held;

    add(32'h3F80_0000, 32'h0000_8000, 1'b0, 1'b0, 10);  // 1.0
    add(32'hC020_0000, 32'hFFFE_C000, 1'b0, 1'b0, 9);   // -2.5
    add(32'h3840_0000, 32'h0000_0002, 1'b0, 1'b0, 25);  // 1.5 LSB
    add(32'h3780_0000, 32'h0000_0000, 1'b0, 1'b0, 26);  // 0.5 LSB tie
    add(32'h4974_2400, 32'h7FFF_FFFF, 1'b1, 1'b0, 1);   // 1e6
    add(32'hFF80_0000, 32'h8000_0000, 1'b1, 1'b0, 1);   // -inf
    add(32'h7FC0_0000, 32'h0000_0000, 1'b0, 1'b1, 1);   // NaN
    add(32'h42FE_0000, 32'h003F_8000, 1'b0, 1'b0, 4);   // 127.0
    add(32'h4400_0000, 32'h0100_0000, 1'b0, 1'b0, 3);   // 512.0, k=1
    add(32'h477F_FFFF, 32'h7FFF_FF80, 1'b0, 1'b0, 9);   // k=7 max mantissa
    add(32'h4380_0000, 32'h0080_0000, 1'b0, 1'b0, 2);   // 256.0, k=0
    add(32'h4780_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1);   // k=8
    add(32'hC780_0000, 32'h8000_0000, 1'b1, 1'b0, 1);   // -65536, k=8
    add(32'h3700_0000, 32'h0000_0000, 1'b0, 1'b0, 1);   // k=-25
    add(32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0, 1);   // denormal
    add(32'h38A0_0000, 32'h0000_0002, 1'b0, 1'b0, 24);  // 2.5 LSB tie
    add(32'h38E0_0000, 32'h0000_0004, 1'b0, 1'b0, 24);  // 3.5 LSB tie
    add(32'hB840_0000, 32'hFFFF_FFFE, 1'b0, 1'b0, 25);  // -1.5 LSB
    add(32'h3780_0001, 32'h0000_0001, 1'b0, 1'b0, 26);  // just above 0.5 LSB
    add(32'h7F80_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1);   // +inf
    add(32'hC700_0000, 32'hC000_0000, 1'b0, 1'b0, 9);   // -32768.0
    add(32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0, 1);   // -0

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset in_ready", {31'd0, in_ready}, 32'd1);
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset out_data", out_data, 32'd0);
    check("reset flags", {30'd0, out_ovf, out_inv}, 32'd0);

    foreach (vecs[i]) begin
      send(vecs[i].din, lat);
      check($sformatf("vec%0d latency", i), lat, vecs[i].lat);
      check($sformatf("vec%0d data", i), out_data, vecs[i].dout);
      check($sformatf("vec%0d flags", i), {30'd0, out_ovf, out_inv},
            {30'd0, vecs[i].ovf, vecs[i].inv});
      drain();
    end

    // Backpressure: result must hold, then a simultaneous out_ready/in_valid
    // must defer the accept by one edge.
    send(32'h3F80_0000, lat);
    check("bp latency", lat, 10);
    held = out_data;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check("bp out_valid held", {31'd0, out_valid}, 32'd1);
      check("bp data held", out_data, held);
      check("bp in_ready low", {31'd0, in_ready}, 32'd0);
    end
    check("bp data value", out_data, 32'h0000_8000);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h4000_0000;  // 2.0
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp no accept in DONE", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp accept next edge", {31'd0, in_ready}, 32'd0);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("bp second latency", lat, 9);
    check("bp second data", out_data, 32'h0001_0000);
    drain();

    // Reset while a saturated result is waiting in DONE.
    send(32'h4974_2400, lat);
    check("pre-reset ovf", {31'd0, out_ovf}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst DONE out_valid", {31'd0, out_valid}, 32'd0);
    check("rst DONE out_data", out_data, 32'd0);
    check("rst DONE flags", {30'd0, out_ovf, out_inv}, 32'd0);
    check("rst DONE in_ready", {31'd0, in_ready}, 32'd1);

    // Reset during SHIFT of 1.0 leaves a nonzero result behind first.
    send(32'hC020_0000, lat);
    drain();
    @(negedge clk);
    in_data  = 32'h3F80_0000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst SHIFT in_ready", {31'd0, in_ready}, 32'd1);
    check("rst SHIFT out_valid", {31'd0, out_valid}, 32'd0);
    check("rst SHIFT out_data", out_data, 32'd0);
    check("rst SHIFT flags", {30'd0, out_ovf, out_inv}, 32'd0);
    seen = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("discarded result never shown", seen, 0);
    send(32'h0000_0000, lat);
    check("post-reset zero latency", lat, 1);
    check("post-reset zero data", out_data, 32'd0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
